// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory.
// Latency: one WRITE cycle after the last byte of each word; done/error one cycle after the checksum byte.
// Backpressure: in_ready drops for the WRITE cycle and after the frame ends until reload.
module program_loader #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   reload,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_run,
  output logic                   done,
  output logic                   error
);

  localparam int BPW = INSTR_WIDTH / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);
  // Memory depth as a wide constant so a full-depth frame (N = 2^ADDR_WIDTH) is legal.
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_en_q;
  logic [15:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [BW-1:0]          byte_q, byte_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic [7:0]             csum_q, csum_d;

  logic                   accept;
  logic [15:0]            len_new;
  logic [INSTR_WIDTH+7:0] shifted;
  logic                   last_word;

  assign accept    = in_valid && in_ready;
  assign len_new   = {n_q[15:8], in_data};
  assign shifted   = {word_q, in_data};
  // Index is compared in a wide domain so N-1 = 2^ADDR_WIDTH-1 never aliases.
  assign last_word = (33'(idx_q) == (33'(n_q) - 33'd1));

  // in_ready stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en_q <= 1'b0;
    else      ready_en_q <= 1'b1;
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LEN_HI;
      n_q     <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
    end
  end

  // Next-state logic: bytes only move the frame forward when actually accepted.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    word_d  = word_q;
    csum_d  = csum_q;
    unique case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          n_d     = {in_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          n_d = len_new;
          if (len_new == 16'd0)             state_d = S_CHECK;
          else if (33'(len_new) > DEPTH)    state_d = S_ERR;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = shifted[INSTR_WIDTH-1:0];
          csum_d = csum_q ^ in_data;
          if (byte_q == LAST_BYTE) begin
            byte_d  = '0;
            state_d = S_WRITE;
          end else begin
            byte_d  = byte_q + BW'(1);
          end
        end
      end
      S_WRITE: begin
        // The index may wrap after the final word; it is unused once in CHECK.
        idx_d   = idx_q + ADDR_WIDTH'(1);
        state_d = last_word ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          idx_d   = '0;
          byte_d  = '0;
          csum_d  = '0;
          state_d = S_LEN_HI;
        end
      end
      default: state_d = S_LEN_HI;
    endcase
  end

  // Outputs decoded from state; memory bus shows the current index and assembled word.
  always_comb begin
    in_ready  = ready_en_q && ((state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                               (state_q == S_DATA)   || (state_q == S_CHECK));
    mem_we    = (state_q == S_WRITE);
    mem_addr  = idx_q;
    mem_wdata = word_q;
    done      = (state_q == S_DONE);
    cpu_run   = (state_q == S_DONE);
    error     = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        done;
  logic        error;

  program_loader #(.INSTR_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          gap_max = 0;
  logic [39:0] exp_wr[$];
  logic [7:0]  frame_q[$];
  logic        mon_last_xfer;
  logic [39:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  // Offer one byte after a random idle gap; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int g;
    int w;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    w = 0;
    in_valid = 1'b0;
    repeat (g) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Reference model: parse the frame as a byte stream, queue the expected writes,
  // drive the bytes the loader should consume, then check the final status.
  task automatic run_frame(input string tag, input int reload_at);
    int          n;
    int          nsend;
    logic [7:0]  cs;
    logic [31:0] word;
    logic        exp_done;
    n  = int'({frame_q[0], frame_q[1]});
    cs = 8'h00;
    if (n > 256) begin
      exp_done = 1'b0;
      nsend    = 2;
    end else begin
      for (int w = 0; w < n; w++) begin
        word = 32'h0;
        for (int k = 0; k < 4; k++) begin
          word = {word[23:0], frame_q[2 + 4*w + k]};
          cs   = cs ^ frame_q[2 + 4*w + k];
        end
        exp_wr.push_back({8'(w), word});
      end
      exp_done = (frame_q[2 + 4*n] == cs);
      nsend    = 3 + 4*n;
    end
    for (int i = 0; i < nsend; i++) begin
      if (i == reload_at) pulse_reload();
      send_byte(frame_q[i]);
    end
    chk({tag, "_done"},     64'(done),          64'(exp_done));
    chk({tag, "_error"},    64'(error),         64'(!exp_done));
    chk({tag, "_cpu_run"},  64'(cpu_run),       64'(exp_done));
    chk({tag, "_in_ready"}, 64'(in_ready),      64'd0);
    chk({tag, "_writes"},   64'(exp_wr.size()), 64'd0);
    exp_wr.delete();
  endtask

  task automatic load_frame(input logic [7:0] f[], input int len);
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(f[i]);
  endtask

  task automatic build_rand(input int n, input bit bad);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      cs = cs ^ b;
      frame_q.push_back(b);
    end
    frame_q.push_back(bad ? (cs ^ 8'($urandom_range(255, 1))) : cs);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_mem_we"},    64'(mem_we),    64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_cpu_run"},   64'(cpu_run),   64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
    chk({tag, "_error"},     64'(error),     64'd0);
  endtask

  logic [7:0] f_good[];
  logic [7:0] f_bad[];

  initial begin
    f_good = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    f_bad  = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h45};
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    mon_last_xfer = 1'b0;

    // Write monitor: every mem_we must match the next queued write and follow a transfer.
    fork
      forever begin
        @(negedge clk);
        if (rst && mem_we) begin
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
          end else begin
            mon_e = exp_wr.pop_front();
            if ({mem_addr, mem_wdata} !== mon_e || !mon_last_xfer) begin
              errors++;
              $display("FAIL mem_write: got addr %0h data %0h after_xfer %0b expected addr %0h data %0h after_xfer 1",
                       mem_addr, mem_wdata, mon_last_xfer, mon_e[39:32], mon_e[31:0]);
            end
          end
        end
        mon_last_xfer = rst && in_valid && in_ready;
      end
    join_none

    // Reset values, then in_ready rising on the first edge after release.
    #12;
    chk_reset_outputs("reset");
    tick();
    rst = 1'b1;
    chk("release_in_ready_pre", 64'(in_ready), 64'd0);
    tick();
    chk("release_in_ready_post", 64'(in_ready), 64'd1);

    // Two-word frame, good checksum.
    load_frame(f_good, 11);
    run_frame("good", -1);

    // Bad checksum: writes still occur, then error; reload and recover.
    pulse_reload();
    load_frame(f_bad, 11);
    run_frame("badcs", -1);
    pulse_reload();
    load_frame(f_good, 11);
    run_frame("recover", -1);

    // Empty frame.
    pulse_reload();
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", -1);

    // Oversized frame N=257: error straight after LEN_LO.
    pulse_reload();
    frame_q = '{8'h01, 8'h01};
    run_frame("oversize", -1);

    // Reset mid-frame discards the partial frame.
    pulse_reload();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b0;
    #2;
    chk_reset_outputs("midreset");
    tick();
    rst = 1'b1;
    load_frame(f_good, 11);
    run_frame("after_reset", -1);

    // reload while mid-frame has no effect.
    pulse_reload();
    load_frame(f_good, 11);
    run_frame("reload_ignored", 1);

    // Same frame with random valid gaps.
    gap_max = 4;
    pulse_reload();
    load_frame(f_good, 11);
    run_frame("gaps", -1);

    // Randomized frames with random gaps and occasional corrupt checksums.
    for (int t = 0; t < 12; t++) begin
      pulse_reload();
      build_rand(int'($urandom_range(6, 1)), ($urandom_range(3, 0) == 0));
      run_frame("rand", -1);
    end

    // Full-depth frame: addresses 0..255 with no wrap.
    gap_max = 1;
    pulse_reload();
    build_rand(256, 1'b0);
    run_frame("full_depth", -1);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
